// File: rtl/gamma_lut_stream.sv
// Per-channel double-buffered gamma LUT. Latency 2 cycles, 1 pixel/cycle, no backpressure.
// Define GAMMA_LUT_BYPASS_EN to add a bypass input latched at each frame start.
module gamma_lut_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_vs,
  input  logic                           in_hs,
  input  logic                           in_de,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_vs,
  output logic                           out_hs,
  output logic                           out_de,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  input  logic                           cfg_we,
  input  logic [1:0]                     cfg_ch,
  input  logic [DATA_WIDTH-1:0]          cfg_addr,
  input  logic [DATA_WIDTH-1:0]          cfg_wdata,
  input  logic                           cfg_commit,
  output logic                           cfg_busy,
  output logic                           active_bank
`ifdef GAMMA_LUT_BYPASS_EN
  ,
  input  logic                           bypass
`endif
);

  localparam int DEPTH = 1 << DATA_WIDTH;
  localparam int PW    = CHANNELS * DATA_WIDTH;

  logic          r_vs_s1, r_hs_s1, r_de_s1;
  logic          r_pending, r_active_bank, r_lut_valid;
  logic [PW-1:0] r_addr_s1, r_pass_s2;
  logic          r_bank_s1, r_use_lut_s1, r_use_lut_s2;
  logic [PW-1:0] w_lut_s2;
  logic          w_vs_rise, w_swap, w_bank_nxt, w_valid_nxt, w_wr_en, w_bypass_nxt;

  // r_vs_s1 doubles as the vs history register for frame-start detection
  assign w_vs_rise   = in_vs & ~r_vs_s1;
  assign w_swap      = w_vs_rise & r_pending;
  assign w_bank_nxt  = r_active_bank ^ w_swap;
  assign w_valid_nxt = r_lut_valid | w_swap;
  assign w_wr_en     = cfg_we & ~r_pending & ({1'b0, cfg_ch} < 3'(CHANNELS));

`ifdef GAMMA_LUT_BYPASS_EN
  logic r_bypass_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_bypass_q <= 1'b0;
    else if (w_vs_rise) r_bypass_q <= bypass;
  end
  assign w_bypass_nxt = w_vs_rise ? bypass : r_bypass_q;
`else
  assign w_bypass_nxt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_s1       <= 1'b0;
      r_hs_s1       <= 1'b0;
      r_de_s1       <= 1'b0;
      r_pending     <= 1'b0;
      r_active_bank <= 1'b0;
      r_lut_valid   <= 1'b0;
      r_addr_s1     <= '0;
      r_bank_s1     <= 1'b0;
      r_use_lut_s1  <= 1'b0;
      r_pass_s2     <= '0;
      r_use_lut_s2  <= 1'b0;
      out_vs        <= 1'b0;
      out_hs        <= 1'b0;
      out_de        <= 1'b0;
    end else begin
      r_vs_s1       <= in_vs;
      r_hs_s1       <= in_hs;
      r_de_s1       <= in_de;
      r_pending     <= w_swap ? 1'b0 : (r_pending | cfg_commit);
      r_active_bank <= w_bank_nxt;
      r_lut_valid   <= w_valid_nxt;
      // the pixel sampled on the swap edge already looks up the new bank
      r_addr_s1     <= in_data;
      r_bank_s1     <= w_bank_nxt;
      r_use_lut_s1  <= w_valid_nxt & ~w_bypass_nxt;
      r_pass_s2     <= r_addr_s1;
      r_use_lut_s2  <= r_use_lut_s1;
      out_vs        <= r_vs_s1;
      out_hs        <= r_hs_s1;
      out_de        <= r_de_s1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] r_mem [2*DEPTH];
    logic [DATA_WIDTH-1:0] r_rd;

    // writes only ever hit the inactive bank, so no read/write collision
    always_ff @(posedge clk) begin
      if (w_wr_en && (cfg_ch == 2'(c)))
        r_mem[{~r_active_bank, cfg_addr}] <= cfg_wdata;
      r_rd <= r_mem[{r_bank_s1, r_addr_s1[c*DATA_WIDTH +: DATA_WIDTH]}];
    end

    assign w_lut_s2[c*DATA_WIDTH +: DATA_WIDTH] = r_rd;
  end

  assign out_data    = r_use_lut_s2 ? w_lut_s2 : r_pass_s2;
  assign cfg_busy    = r_pending;
  assign active_bank = r_active_bank;

endmodule

// File: tb/tb_gamma_lut_stream.sv
// Randomised bench for gamma_lut_stream with a frame-level reference model.
module tb_gamma_lut_stream;
  localparam int DW = 8;
  localparam int CH = 3;
  localparam int PW = CH * DW;

  logic          clk, rst;
  logic          in_vs, in_hs, in_de;
  logic [PW-1:0] in_data;
  logic          out_vs, out_hs, out_de;
  logic [PW-1:0] out_data;
  logic          cfg_we, cfg_commit;
  logic [1:0]    cfg_ch;
  logic [DW-1:0] cfg_addr, cfg_wdata;
  logic          cfg_busy, active_bank;

  gamma_lut_stream #(.DATA_WIDTH(DW), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst),
    .in_vs(in_vs), .in_hs(in_hs), .in_de(in_de), .in_data(in_data),
    .out_vs(out_vs), .out_hs(out_hs), .out_de(out_de), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .active_bank(active_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: curve tables per bank/channel, frame-level swap rules,
  // and the two pixels currently in flight.
  logic [DW-1:0]  tab [2][4][256];
  logic           m_prev_vs = 1'b0, m_pending = 1'b0, m_bank = 1'b0, m_valid = 1'b0;
  logic [PW+2:0]  e1 = '0, e2 = '0;
  logic           m_rise;
  logic [PW-1:0]  m_px;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev_vs = 1'b0; m_pending = 1'b0; m_bank = 1'b0; m_valid = 1'b0;
      e1 = '0; e2 = '0;
    end else begin
      m_rise    = in_vs && !m_prev_vs;
      m_prev_vs = in_vs;
      e2 = e1;
      if (cfg_we && !m_pending && (int'(cfg_ch) < CH))
        tab[!m_bank][cfg_ch][cfg_addr] = cfg_wdata;
      if (m_rise && m_pending) begin
        m_bank = !m_bank; m_valid = 1'b1; m_pending = 1'b0;
      end else if (cfg_commit) begin
        m_pending = 1'b1;
      end
      for (int c = 0; c < CH; c++)
        m_px[c*DW +: DW] = m_valid ? tab[m_bank][c][in_data[c*DW +: DW]] : in_data[c*DW +: DW];
      e1 = {in_vs, in_hs, in_de, m_px};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pipe_out", {out_vs, out_hs, out_de, out_data}, e2);
      check("cfg_busy", cfg_busy, m_pending);
      check("active_bank", active_bank, m_bank);
    end
  end

  task automatic drive(input logic vs, input logic hs, input logic de, input logic [PW-1:0] d);
    in_vs = vs; in_hs = hs; in_de = de; in_data = d;
    @(negedge clk);
  endtask

  task automatic drive_rand();
    drive(1'b0, 1'($urandom), 1'($urandom), PW'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    in_vs = 0; in_hs = 0; in_de = 0; in_data = '0;
    cfg_we = 0; cfg_commit = 0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_out", {out_vs, out_hs, out_de, out_data}, 32'h0);
    check("reset_busy", cfg_busy, 1'b0);
    check("reset_bank", active_bank, 1'b0);
    rst = 1'b0;

    // identity after reset
    drive(1'b0, 1'b1, 1'b1, 24'h102030);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    check("ident_data", out_data, 24'h102030);
    check("ident_syncs", {out_hs, out_de}, 2'b11);

    // inverse curve into bank 1 on every channel
    for (int ch = 0; ch < CH; ch++)
      for (int a = 0; a < 256; a++) begin
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_addr = 8'(a); cfg_wdata = 8'(255 - a);
        drive_rand();
      end
    cfg_we = 1'b0;

    cfg_commit = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    cfg_commit = 1'b0;
    check("commit_busy", cfg_busy, 1'b1);

    // this write must be dropped because a swap is pending
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 8'h10; cfg_wdata = 8'h55;
    drive_rand();
    cfg_we = 1'b0;
    drive_rand();

    drive(1'b1, 1'b0, 1'b1, 24'h00FF80);
    check("swap_bank", active_bank, 1'b1);
    check("swap_busy", cfg_busy, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 24'h000010);
    check("inverse_px", out_data, 24'hFF007F);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    check("busy_drop_px", out_data, 24'hFFFFEF);

    // random curve into bank 0; channel 3 writes are out of range
    for (int ch = 0; ch < 4; ch++)
      for (int a = 0; a < 256; a++) begin
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_addr = 8'(a); cfg_wdata = 8'($urandom);
        drive_rand();
      end
    cfg_we = 1'b0;

    // commit on the vs_rise edge itself
    cfg_commit = 1'b1;
    drive(1'b1, 1'b0, 1'b0, PW'($urandom));
    cfg_commit = 1'b0;
    check("same_edge_bank", active_bank, 1'b1);
    check("same_edge_busy", cfg_busy, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 1'b1, PW'($urandom));
    repeat (3) drive_rand();
    check("same_edge_hold", active_bank, 1'b1);
    drive(1'b1, 1'b0, 1'b1, PW'($urandom));
    check("same_edge_swap", active_bank, 1'b0);
    check("same_edge_clr", cfg_busy, 1'b0);

    // random frames, writes and commits
    for (int i = 0; i < 3000; i++) begin
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_ch     = 2'($urandom);
      cfg_addr   = 8'($urandom);
      cfg_wdata  = 8'($urandom);
      cfg_commit = ($urandom_range(0, 149) == 0);
      drive((i % 97) < 3, 1'($urandom), 1'($urandom), PW'($urandom));
    end
    cfg_we = 1'b0; cfg_commit = 1'b0;

    // mid-frame reset
    repeat (5) drive(1'b0, 1'b1, 1'b1, PW'($urandom));
    #2 rst = 1'b1;
    #1;
    check("rst_out", {out_vs, out_hs, out_de, out_data}, 32'h0);
    check("rst_bank", active_bank, 1'b0);
    check("rst_busy", cfg_busy, 1'b0);
    @(negedge clk);
    repeat (2) drive_rand();
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 24'hABCDEF);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    check("post_rst_ident", out_data, 24'hABCDEF);
    check("post_rst_bank", active_bank, 1'b0);
    repeat (3) drive_rand();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
